kan_tile_accumulator: RTL and testbench

- Next-generation output stage of the RSWAF data processor, placed after the linear processing array.
- Accepts CHANNELS parallel partial-sum lanes, one per weight channel, as a single AXI-Stream.
- Accumulates partial sums over a run-time number of tile passes, so a layer wider than DATA_CHANNELS is processed in several grid/input tiles.
- On the final pass, rounds and saturates each lane and emits the finished neuron vector.

---
 rtl/kan_tile_accumulator_pkg.sv | 49 ++++
 rtl/kan_acc_lane.sv | 42 ++++
 rtl/kan_tile_accumulator.sv | 220 ++++++++++++++++++++++
 tb/tb_kan_tile_accumulator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kan_tile_accumulator_pkg.sv
// Shared definitions for the KAN tile accumulator: FSM encoding,
// saturation / rounding arithmetic and lane slicing.
package kan_tile_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FINAL = 2'd2
  } kan_state_e;

  // Clamp a signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

  // True when sat_clamp would have to modify the value.
  function automatic logic sat_hit(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  // Drop d LSBs with round-half-up; d == 0 passes the value through.
  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v, input int d);
    if (d == 0) begin
      return v;
    end else begin
      return (v + (64'sd1 <<< (d - 1))) >>> d;
    end
  endfunction

  // Bit offset of lane 'lane' inside a packed vector of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/kan_acc_lane.sv
// One accumulator lane: add the partial sum to the stored value (or take it
// alone on the first pass), saturate to the accumulator width, then round
// and saturate to the output width. Purely combinational.
module kan_acc_lane
  import kan_tile_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16,
  parameter int RND_BITS  = 0
) (
  input  logic [IN_WIDTH-1:0]  in_i,
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic                 first_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic [OUT_WIDTH-1:0] res_o,
  output logic                 ovf_acc_o,
  output logic                 ovf_out_o
);

  logic signed [63:0] in_ext;
  logic signed [63:0] acc_ext;
  logic signed [63:0] raw_sum;
  logic signed [63:0] sat_sum;
  logic signed [63:0] rnd_val;
  logic signed [63:0] out_val;

  // Lane arithmetic: extend, add, clamp, round, clamp.
  always_comb begin
    in_ext    = {{(64 - IN_WIDTH){in_i[IN_WIDTH-1]}}, in_i};
    acc_ext   = {{(64 - ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
    raw_sum   = first_i ? in_ext : (acc_ext + in_ext);
    sat_sum   = sat_clamp(raw_sum, ACC_WIDTH);
    ovf_acc_o = first_i ? 1'b0 : sat_hit(raw_sum, ACC_WIDTH);
    rnd_val   = round_half_up(sat_sum, RND_BITS);
    out_val   = sat_clamp(rnd_val, OUT_WIDTH);
    ovf_out_o = sat_hit(rnd_val, OUT_WIDTH);
    sum_o     = sat_sum[ACC_WIDTH-1:0];
    res_o     = out_val[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/kan_tile_accumulator.sv
// Multi-pass partial-sum accumulator: sums CHANNELS lanes over T tile passes
// and emits the rounded, saturated vector during the final pass.
module kan_tile_accumulator
  import kan_tile_accumulator_pkg::*;
#(
  parameter int CHANNELS            = 4,
  parameter int IN_WIDTH            = 16,
  parameter int IN_FRACTIONAL_BITS  = 12,
  parameter int ACC_WIDTH           = 24,
  parameter int OUT_WIDTH           = 16,
  parameter int OUT_FRACTIONAL_BITS = 12,
  parameter int DEPTH               = 16,
  parameter int TILE_COUNT_WIDTH    = 8,
  parameter int ID_ENABLE           = 0,
  parameter int ID_WIDTH            = 1,
  parameter int DEST_ENABLE         = 0,
  parameter int DEST_WIDTH          = 1,
  parameter int USER_ENABLE         = 0,
  parameter int USER_WIDTH          = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TILE_COUNT_WIDTH-1:0]   cfg_tiles,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0]  s_axis_psum_tdata,
  input  logic                          s_axis_psum_tvalid,
  output logic                          s_axis_psum_tready,
  input  logic                          s_axis_psum_tlast,
  input  logic [ID_WIDTH-1:0]           s_axis_psum_tid,
  input  logic [DEST_WIDTH-1:0]         s_axis_psum_tdest,
  input  logic [USER_WIDTH-1:0]         s_axis_psum_tuser,
  output logic [CHANNELS*OUT_WIDTH-1:0] m_axis_rslt_tdata,
  output logic                          m_axis_rslt_tvalid,
  input  logic                          m_axis_rslt_tready,
  output logic                          m_axis_rslt_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_rslt_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_rslt_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_rslt_tuser,
  output logic                          busy,
  output logic                          err_len_mismatch,
  output logic                          err_overflow
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW  = TILE_COUNT_WIDTH;
  localparam int RND = IN_FRACTIONAL_BITS - OUT_FRACTIONAL_BITS;

  kan_state_e state_q, state_d;
  logic [TW-1:0] tiles_q, tiles_d, pass_q, pass_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   len_q, len_d;
  logic          err_len_q, err_len_d, err_ovf_q, err_ovf_d;
  logic [CHANNELS*OUT_WIDTH-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
  logic [DEST_WIDTH-1:0] m_dest_q, m_dest_d;
  logic [USER_WIDTH-1:0] m_user_q, m_user_d;

  logic [CHANNELS*ACC_WIDTH-1:0] acc_q [DEPTH];
  logic [CHANNELS*ACC_WIDTH-1:0] acc_rd, acc_wr;
  logic [CHANNELS*OUT_WIDTH-1:0] res;
  logic [CHANNELS-1:0]           ovf_acc, ovf_out;
  logic s_ready, acc_we, first, pass_end, len_bad, to_final;
  logic [AW:0] addr_plus1;

  assign acc_rd     = acc_q[addr_q];
  assign first      = (pass_q == '0);
  assign pass_end   = s_axis_psum_tlast || (addr_q == AW'(DEPTH - 1));
  assign addr_plus1 = (AW+1)'(addr_q) + (AW+1)'(1);
  assign len_bad    = pass_end && (!s_axis_psum_tlast || (!first && (addr_plus1 != len_q)));
  assign to_final   = ((TW+1)'(pass_q) + (TW+1)'(2)) == (TW+1)'(tiles_q);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    kan_acc_lane #(
      .IN_WIDTH (IN_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .RND_BITS (RND)
    ) u_lane (
      .in_i     (s_axis_psum_tdata[lane_lsb(g, IN_WIDTH) +: IN_WIDTH]),
      .acc_i    (acc_rd[lane_lsb(g, ACC_WIDTH) +: ACC_WIDTH]),
      .first_i  (first),
      .sum_o    (acc_wr[lane_lsb(g, ACC_WIDTH) +: ACC_WIDTH]),
      .res_o    (res[lane_lsb(g, OUT_WIDTH) +: OUT_WIDTH]),
      .ovf_acc_o(ovf_acc[g]),
      .ovf_out_o(ovf_out[g])
    );
  end

  // Next-state, counter, error and output-register logic.
  always_comb begin
    state_d   = state_q;
    tiles_d   = tiles_q;
    pass_d    = pass_q;
    addr_d    = addr_q;
    len_d     = len_q;
    err_len_d = err_len_q;
    err_ovf_d = err_ovf_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    m_dest_d  = m_dest_q;
    m_user_d  = m_user_q;
    s_ready   = 1'b0;
    acc_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          tiles_d   = (cfg_tiles == '0) ? TW'(1) : cfg_tiles;
          err_len_d = 1'b0;
          err_ovf_d = 1'b0;
          pass_d    = '0;
          addr_d    = '0;
          state_d   = (cfg_tiles <= TW'(1)) ? ST_FINAL : ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        s_ready = 1'b1;
        if (s_axis_psum_tvalid) begin
          acc_we    = 1'b1;
          err_ovf_d = err_ovf_q | (|ovf_acc);
          err_len_d = err_len_q | len_bad;
          if (pass_end) begin
            len_d   = first ? addr_plus1 : len_q;
            addr_d  = '0;
            pass_d  = pass_q + TW'(1);
            state_d = to_final ? ST_FINAL : ST_ACCUM;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end else begin
          acc_we = 1'b0;
        end
      end
      ST_FINAL: begin
        // Hold off new input once the last result waits in the register.
        s_ready = !m_valid_q || (m_axis_rslt_tready && !m_last_q);
        if (m_valid_q && m_axis_rslt_tready) begin
          m_valid_d = 1'b0;
          state_d   = m_last_q ? ST_IDLE : ST_FINAL;
        end else begin
          m_valid_d = m_valid_q;
        end
        if (s_axis_psum_tvalid && s_ready) begin
          m_data_d  = res;
          m_valid_d = 1'b1;
          m_last_d  = pass_end;
          m_id_d    = (ID_ENABLE != 0) ? s_axis_psum_tid : '0;
          m_dest_d  = (DEST_ENABLE != 0) ? s_axis_psum_tdest : '0;
          m_user_d  = (USER_ENABLE != 0) ? s_axis_psum_tuser : '0;
          err_ovf_d = err_ovf_q | (|ovf_acc) | (|ovf_out);
          err_len_d = err_len_q | len_bad;
          addr_d    = pass_end ? '0 : (addr_q + AW'(1));
        end else begin
          m_data_d = m_data_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tiles_q   <= '0;
      pass_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
      m_dest_q  <= '0;
      m_user_q  <= '0;
    end else begin
      state_q   <= state_d;
      tiles_q   <= tiles_d;
      pass_q    <= pass_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_id_q    <= m_id_d;
      m_dest_q  <= m_dest_d;
      m_user_q  <= m_user_d;
    end
  end

  // Accumulator storage; pass 0 overwrites it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc_q[addr_q] <= acc_wr;
    end
  end

  assign cfg_ready          = (state_q == ST_IDLE);
  assign busy               = (state_q != ST_IDLE);
  assign s_axis_psum_tready = s_ready;
  assign m_axis_rslt_tdata  = m_data_q;
  assign m_axis_rslt_tvalid = m_valid_q;
  assign m_axis_rslt_tlast  = m_last_q;
  assign m_axis_rslt_tid    = m_id_q;
  assign m_axis_rslt_tdest  = m_dest_q;
  assign m_axis_rslt_tuser  = m_user_q;
  assign err_len_mismatch   = err_len_q;
  assign err_overflow       = err_ovf_q;

endmodule

// File: tb/tb_kan_tile_accumulator.sv
// Directed, table-driven bench for kan_tile_accumulator with two lanes.
module tb_kan_tile_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_tiles;
  logic        cfg_valid, cfg_ready;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic        s_tid, s_tdest, s_tuser;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        m_tid, m_tdest, m_tuser;
  logic        busy, err_len, err_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kan_tile_accumulator #(
    .CHANNELS(2), .USER_ENABLE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_tiles(cfg_tiles), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .s_axis_psum_tdata(s_tdata), .s_axis_psum_tvalid(s_tvalid),
    .s_axis_psum_tready(s_tready), .s_axis_psum_tlast(s_tlast),
    .s_axis_psum_tid(s_tid), .s_axis_psum_tdest(s_tdest), .s_axis_psum_tuser(s_tuser),
    .m_axis_rslt_tdata(m_tdata), .m_axis_rslt_tvalid(m_tvalid),
    .m_axis_rslt_tready(m_tready), .m_axis_rslt_tlast(m_tlast),
    .m_axis_rslt_tid(m_tid), .m_axis_rslt_tdest(m_tdest), .m_axis_rslt_tuser(m_tuser),
    .busy(busy), .err_len_mismatch(err_len), .err_overflow(err_ovf)
  );

  typedef struct {
    logic [15:0] i0;
    logic [15:0] i1;
    logic        last;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic do_cfg(input logic [7:0] t);
    logic rdy;
    logic ok;
    ok        = 1'b0;
    cfg_tiles = t;
    cfg_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1 rdy = cfg_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("cfg_timeout", 64'd0, 64'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    logic rdy;
    logic ok;
    ok       = 1'b0;
    s_tdata  = {b, a};
    s_tlast  = last;
    s_tuser  = last;
    s_tvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1 rdy = s_tready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk(name, {63'd0, busy}, 64'd0);
  endtask

  task automatic apply_vec(input int idx);
    send_beat(tbl[idx].i0, tbl[idx].i1, tbl[idx].last);
    chk("vec_valid", {63'd0, m_tvalid}, 64'd1);
    chk("vec_data", {32'd0, m_tdata}, {32'd0, tbl[idx].e1, tbl[idx].e0});
    chk("vec_last", {63'd0, m_tlast}, {63'd0, tbl[idx].last});
    chk("vec_user", {63'd0, m_tuser}, {63'd0, tbl[idx].last});
  endtask

  logic [31:0] got [8];
  int          n_got;
  logic        held;
  logic [31:0] prev;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h1000, 16'hF800, 1'b0, 16'h1000, 16'hF800};
    tbl[1] = '{16'h1000, 16'hF800, 1'b0, 16'h1000, 16'hF800};
    tbl[2] = '{16'h1000, 16'hF800, 1'b1, 16'h1000, 16'hF800};
    tbl[3] = '{16'h0800, 16'hFFFF, 1'b0, 16'h1800, 16'hFFFD};
    tbl[4] = '{16'h0800, 16'hFFFF, 1'b0, 16'h1800, 16'hFFFD};
    tbl[5] = '{16'h0800, 16'hFFFF, 1'b0, 16'h1800, 16'hFFFD};
    tbl[6] = '{16'h0800, 16'hFFFF, 1'b1, 16'h1800, 16'hFFFD};

    rst = 1'b1; cfg_tiles = 8'd0; cfg_valid = 1'b0;
    s_tdata = 32'd0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tid = 1'b0; s_tdest = 1'b0; s_tuser = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_errs", {62'd0, err_len, err_ovf}, 64'd0);
    rst = 1'b0;

    // 1: single pass passes data through with one cycle of latency.
    do_cfg(8'd1);
    for (int i = 0; i < 3; i++) apply_vec(i);
    wait_idle("t1_idle");
    chk("t1_cfg_ready", {63'd0, cfg_ready}, 64'd1);

    // 2: three passes; cfg_valid offered mid-run must be ignored.
    do_cfg(8'd3);
    cfg_tiles = 8'd1; cfg_valid = 1'b1;
    #1 chk("t2_cfg_ready_busy", {63'd0, cfg_ready}, 64'd0);
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 4; b++) begin
        send_beat(16'h0800, 16'hFFFF, (b == 3));
        chk("t2_no_out", {63'd0, m_tvalid}, 64'd0);
      end
      cfg_valid = 1'b0;
    end
    for (int i = 3; i < 7; i++) apply_vec(i);
    wait_idle("t2_idle");
    chk("t2_errs", {62'd0, err_len, err_ovf}, 64'd0);

    // 3: output saturation sets sticky overflow.
    do_cfg(8'd2);
    send_beat(16'h7000, 16'h0000, 1'b1);
    chk("t3_no_out", {63'd0, m_tvalid}, 64'd0);
    send_beat(16'h7000, 16'h0001, 1'b1);
    chk("t3_sat_data", {32'd0, m_tdata}, {32'd0, 16'h0001, 16'h7FFF});
    chk("t3_ovf", {63'd0, err_ovf}, 64'd1);
    wait_idle("t3_idle");
    chk("t3_ovf_sticky", {63'd0, err_ovf}, 64'd1);

    // 4: short final pass flags a length mismatch; overflow cleared by cfg.
    do_cfg(8'd2);
    chk("t4_ovf_cleared", {63'd0, err_ovf}, 64'd0);
    for (int b = 0; b < 4; b++) send_beat(16'h0100, 16'h0010, (b == 3));
    chk("t4_len_ok", {63'd0, err_len}, 64'd0);
    send_beat(16'h0100, 16'h0010, 1'b0);
    chk("t4_data0", {32'd0, m_tdata}, {32'd0, 16'h0020, 16'h0200});
    chk("t4_last0", {63'd0, m_tlast}, 64'd0);
    send_beat(16'h0100, 16'h0010, 1'b1);
    chk("t4_data1", {32'd0, m_tdata}, {32'd0, 16'h0020, 16'h0200});
    chk("t4_last1", {63'd0, m_tlast}, 64'd1);
    chk("t4_len_err", {63'd0, err_len}, 64'd1);
    wait_idle("t4_idle");

    // 5: sink stalls with tready pattern 1-0-0-1.
    do_cfg(8'd1);
    n_got = 0; held = 1'b0; prev = 32'd0;
    fork
      begin
        @(negedge clk);
        send_beat(16'h0100, 16'h0001, 1'b0);
        send_beat(16'h0200, 16'h0002, 1'b0);
        send_beat(16'h0300, 16'h0003, 1'b1);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          m_tready = !(c == 1 || c == 2);
          #4;
          if (m_tvalid && !m_tready) begin
            chk("t5_stall_s_tready", {63'd0, s_tready}, 64'd0);
            if (held) chk("t5_stall_stable", {32'd0, m_tdata}, {32'd0, prev});
          end
          held = m_tvalid && !m_tready;
          prev = m_tdata;
          if (m_tvalid && m_tready && n_got < 8) begin
            got[n_got] = m_tdata;
            n_got++;
          end
        end
        m_tready = 1'b1;
      end
    join
    chk("t5_count", 64'(n_got), 64'd3);
    chk("t5_beat0", {32'd0, got[0]}, {32'd0, 16'h0001, 16'h0100});
    chk("t5_beat1", {32'd0, got[1]}, {32'd0, 16'h0002, 16'h0200});
    chk("t5_beat2", {32'd0, got[2]}, {32'd0, 16'h0003, 16'h0300});
    wait_idle("t5_idle");

    // 6: reset in the middle of a run, then a fresh single-pass run.
    do_cfg(8'd4);
    send_beat(16'h0100, 16'h0000, 1'b0);
    send_beat(16'h0100, 16'h0000, 1'b1);
    send_beat(16'h0100, 16'h0000, 1'b1);
    chk("t6_len_err", {63'd0, err_len}, 64'd1);
    send_beat(16'h0100, 16'h0000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("t6_rst_errs", {62'd0, err_len, err_ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    s_tvalid = 1'b1;
    #1 chk("t6_idle_no_accept", {63'd0, s_tready}, 64'd0);
    s_tvalid = 1'b0;
    @(negedge clk);
    do_cfg(8'd0);
    send_beat(16'h0123, 16'hFEDC, 1'b1);
    chk("t6_fresh_data", {32'd0, m_tdata}, {32'd0, 16'hFEDC, 16'h0123});
    chk("t6_fresh_last", {63'd0, m_tlast}, 64'd1);
    wait_idle("t6_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
